// File: rtl/sevga_pkg.sv
// sevga_pkg: video timing defaults, snoop write slots and VRAM fetch FSM states
package sevga_pkg;
    localparam int DEF_H_START        = 64;
    localparam int DEF_V_START        = 69;
    localparam int DEF_BYTES_PER_LINE = 64;
    localparam int DEF_V_LINES        = 342;
    localparam int DEF_FETCH_SLOT     = 4;
    localparam int WR_SLOT_LO         = 1;
    localparam int WR_SLOT_HI         = 2;
    typedef enum logic [1:0] {VBLANK, LINE_WAIT, FETCHING, LINE_DONE} fetch_state_t;
endpackage

// File: rtl/pix_shifter.sv
// pix_shifter: byte-to-pixel serialiser with image-active flag; SEVGA_PIX_INVERT_EN flips polarity inside the image
module pix_shifter (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       flush,
    input  logic       valid,
    input  logic [7:0] din,
    output logic       pix,
    output logic       active
);
    logic [7:0] sr_q, sr_d;
    logic       act_q, act_d;
    // load a fetched byte (or blank) once per 8 clocks, shift MSB-first in between
    always_comb begin
        sr_d  = flush ? 8'h00 : load ? (valid ? din : 8'h00) : {sr_q[6:0], 1'b0};
        act_d = flush ? 1'b0 : load ? valid : act_q;
    end
    // shift register and active flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q  <= '0;
            act_q <= 1'b0;
        end else begin
            sr_q  <= sr_d;
            act_q <= act_d;
        end
    end
    assign active = act_q;
`ifdef SEVGA_PIX_INVERT_EN
    assign pix = act_q & ~sr_q[7];
`else
    assign pix = sr_q[7];
`endif
endmodule

// File: rtl/vram_fetch.sv
// vram_fetch: reads the 512x342 frame buffer from VRAM and serialises it centred in VGA (SEVGA_PIX_INVERT_EN: VGA DAC polarity)
module vram_fetch
    import sevga_pkg::*;
#(
    parameter int H_START        = DEF_H_START,
    parameter int V_START        = DEF_V_START,
    parameter int BYTES_PER_LINE = DEF_BYTES_PER_LINE,
    parameter int V_LINES        = DEF_V_LINES,
    parameter int FETCH_SLOT     = DEF_FETCH_SLOT
) (
    input  logic        pixClock,
    input  logic        reset,
    input  logic [9:0]  hCount,
    input  logic [9:0]  vCount,
    input  logic [7:0]  vramDataIn,
    output logic [14:0] vramAddr,
    output logic        nvramOE,
    output logic        pixOut,
    output logic        pixActive
);
    localparam logic [9:0] H_WAIT    = 10'(H_START - 8);
    localparam logic [9:0] V_FIRST   = 10'(V_START);
    localparam logic [5:0] BYTE_LAST = 6'(BYTES_PER_LINE - 1);
    localparam logic [8:0] LINE_LAST = 9'(V_LINES - 1);
    localparam logic [2:0] PRE_SLOT  = 3'(FETCH_SLOT + 7);

    if (FETCH_SLOT == WR_SLOT_LO || FETCH_SLOT == WR_SLOT_HI) begin : g_slot_check
        $error("FETCH_SLOT collides with a snoop write slot");
    end

    fetch_state_t state_q, state_d;
    logic [8:0]   line_q, line_d;
    logic [5:0]   byte_q, byte_d;
    logic [14:0]  addr_q, addr_d;
    logic         oe_n_q, oe_n_d;
    logic [7:0]   fetch_q, fetch_d;
    logic         got_q, got_d;
    logic [2:0]   seq;
    logic         flush, capture, load, line_end;

    assign seq      = hCount[2:0];
    assign flush    = vCount == '0;
    assign capture  = !oe_n_q;
    assign load     = seq == 3'd7;
    assign line_end = state_q == LINE_DONE && hCount == '0;

    // fetch state register
    always_ff @(posedge pixClock or posedge reset) begin
        if (reset) state_q <= VBLANK;
        else state_q <= state_d;
    end

    // next state; VBLANK is left as line V_START begins so its bytes are fetched on that same line
    always_comb begin
        state_d = state_q;
        case (state_q)
            VBLANK:    if (vCount == V_FIRST && hCount == '0) state_d = LINE_WAIT;
            LINE_WAIT: if (hCount == H_WAIT) state_d = FETCHING;
            FETCHING:  if (capture && byte_q == BYTE_LAST) state_d = LINE_DONE;
            default:   if (line_end) state_d = line_q == LINE_LAST ? VBLANK : LINE_WAIT;
        endcase
        if (flush) state_d = VBLANK;
    end

    // counters, read strobe armed one clock ahead of the slot, captured byte and its window flag
    always_comb begin
        line_d  = state_q == VBLANK ? 9'd0 : line_end ? line_q + 9'd1 : line_q;
        byte_d  = state_q == LINE_WAIT ? 6'd0 : capture ? byte_q + 6'd1 : byte_q;
        oe_n_d  = !(state_q == FETCHING && seq == PRE_SLOT && !flush);
        addr_d  = oe_n_d ? addr_q : {line_q, byte_q};
        fetch_d = capture ? vramDataIn : fetch_q;
        got_d   = !load && !flush && (capture || got_q);
    end

    // datapath registers
    always_ff @(posedge pixClock or posedge reset) begin
        if (reset) begin
            line_q  <= '0;
            byte_q  <= '0;
            addr_q  <= '0;
            oe_n_q  <= 1'b1;
            fetch_q <= '0;
            got_q   <= 1'b0;
        end else begin
            line_q  <= line_d;
            byte_q  <= byte_d;
            addr_q  <= addr_d;
            oe_n_q  <= oe_n_d;
            fetch_q <= fetch_d;
            got_q   <= got_d;
        end
    end

    assign vramAddr = addr_q;
    assign nvramOE  = oe_n_q;

    pix_shifter u_shifter (
        .clk    (pixClock),
        .rst    (reset),
        .load   (load),
        .flush  (flush),
        .valid  (capture || got_q),
        .din    (fetch_d),
        .pix    (pixOut),
        .active (pixActive)
    );
endmodule

// File: tb/tb_vram_fetch.sv
// tb_vram_fetch: directed bench for vram_fetch; VRAM model returns the address low byte or 0xAA
module tb_vram_fetch;
    import sevga_pkg::*;
    logic        pixClock = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  hCount = '0;
    logic [9:0]  vCount = '0;
    logic [7:0]  vramDataIn;
    logic [14:0] vramAddr;
    logic        nvramOE, pixOut, pixActive;
    logic        aa_mode = 1'b0;
    logic        mon_en = 1'b0;
    int          total = 0;
    int          bad = 0;
`ifdef SEVGA_PIX_INVERT_EN
    localparam logic INV = 1'b1;
`else
    localparam logic INV = 1'b0;
`endif

    vram_fetch dut (
        .pixClock   (pixClock),
        .reset      (reset),
        .hCount     (hCount),
        .vCount     (vCount),
        .vramDataIn (vramDataIn),
        .vramAddr   (vramAddr),
        .nvramOE    (nvramOE),
        .pixOut     (pixOut),
        .pixActive  (pixActive)
    );

    always #5 pixClock = ~pixClock;
    assign vramDataIn = aa_mode ? 8'hAA : vramAddr[7:0];

    always @(negedge pixClock) begin
        if (mon_en) begin
            total++;
            if (nvramOE === 1'b0 && (hCount[2:0] == 3'd1 || hCount[2:0] == 3'd2)) begin
                bad++;
                $display("FAIL oe_in_write_slot v=%0d h=%0d nvramOE=%b required=1", vCount, hCount, nvramOE);
            end
        end
    end

    task automatic step(input logic [9:0] h, input logic [9:0] v);
        @(posedge pixClock);
        #1;
        hCount = h;
        vCount = v;
        @(negedge pixClock);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        step(10'd0, 10'd0);
        step(10'd1, 10'd0);
        total += 5;
        if (nvramOE !== 1'b1) begin bad++; $display("FAIL reset_oe got=%b want=1", nvramOE); end
        if (vramAddr !== 15'h0) begin bad++; $display("FAIL reset_addr got=%h want=0000", vramAddr); end
        if (pixOut !== 1'b0) begin bad++; $display("FAIL reset_pix got=%b want=0", pixOut); end
        if (pixActive !== 1'b0) begin bad++; $display("FAIL reset_active got=%b want=0", pixActive); end
        if (dut.state_q !== VBLANK) begin bad++; $display("FAIL reset_state got=%0d want=%0d", dut.state_q, VBLANK); end
        reset = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic test_vblank_quiet(input logic [9:0] v, input int n);
        for (int h = 0; h < n; h++) begin
            step(10'(h), v);
            total += 2;
            if (nvramOE !== 1'b1) begin bad++; $display("FAIL quiet_oe v=%0d h=%0d got=%b want=1", v, h, nvramOE); end
            if (pixActive !== 1'b0) begin bad++; $display("FAIL quiet_active v=%0d h=%0d got=%b want=0", v, h, pixActive); end
        end
    endtask

    task automatic test_full_line(input logic [9:0] v, input logic [8:0] ln, input logic aa);
        logic        e_oe, e_act, e_pix;
        logic [7:0]  b;
        logic [14:0] e_addr;
        aa_mode = aa;
        for (int h = 0; h < 800; h++) begin
            step(10'(h), v);
            e_oe   = !(h >= 60 && h <= 564 && h % 8 == 4);
            e_act  = h >= 64 && h <= 575;
            b      = aa ? 8'hAA : {ln[1:0], 6'((h - 64) / 8)};
            e_pix  = e_act && (b[3'(7 - h % 8)] ^ INV);
            e_addr = {ln, 6'((h - 60) / 8)};
            total += 3;
            if (nvramOE !== e_oe) begin bad++; $display("FAIL line_oe v=%0d h=%0d got=%b want=%b", v, h, nvramOE, e_oe); end
            if (pixActive !== e_act) begin bad++; $display("FAIL line_active v=%0d h=%0d got=%b want=%b", v, h, pixActive, e_act); end
            if (pixOut !== e_pix) begin bad++; $display("FAIL line_pix v=%0d h=%0d got=%b want=%b", v, h, pixOut, e_pix); end
            if (!e_oe) begin
                total++;
                if (vramAddr !== e_addr) begin bad++; $display("FAIL line_addr v=%0d h=%0d got=%h want=%h", v, h, vramAddr, e_addr); end
            end
        end
    endtask

    task automatic test_fast_lines;
        aa_mode = 1'b0;
        for (int v = 71; v <= 409; v++) begin
            step(10'd0, 10'(v));
            step(10'd56, 10'(v));
            for (int b = 0; b < 64; b++) begin
                step(10'(59 + 8 * b), 10'(v));
                step(10'(63 + 8 * b), 10'(v));
                total += 2;
                if (nvramOE !== 1'b0) begin bad++; $display("FAIL fast_oe v=%0d b=%0d got=%b want=0", v, b, nvramOE); end
                if (vramAddr !== {9'(v - 69), 6'(b)}) begin
                    bad++;
                    $display("FAIL fast_addr v=%0d b=%0d got=%h want=%h", v, b, vramAddr, {9'(v - 69), 6'(b)});
                end
            end
            step(10'd575, 10'(v));
        end
    endtask

    task automatic test_frame_end;
        for (int h = 0; h < 800; h++) begin
            step(10'(h), 10'd411);
            total += 3;
            if (nvramOE !== 1'b1) begin bad++; $display("FAIL end_oe h=%0d got=%b want=1", h, nvramOE); end
            if (pixActive !== 1'b0) begin bad++; $display("FAIL end_active h=%0d got=%b want=0", h, pixActive); end
            if (vramAddr !== 15'h557F) begin bad++; $display("FAIL end_addr_hold h=%0d got=%h want=557f", h, vramAddr); end
            if (h == 1) begin
                total++;
                if (dut.state_q !== VBLANK) begin bad++; $display("FAIL end_state got=%0d want=%0d", dut.state_q, VBLANK); end
            end
        end
    endtask

    task automatic test_vcount_restart;
        for (int h = 0; h <= 100; h++) step(10'(h), 10'd70);
        total++;
        if (pixActive !== 1'b1) begin bad++; $display("FAIL restart_pre_active got=%b want=1", pixActive); end
        step(10'd101, 10'd0);
        step(10'd102, 10'd0);
        total += 4;
        if (pixActive !== 1'b0) begin bad++; $display("FAIL restart_active got=%b want=0", pixActive); end
        if (pixOut !== 1'b0) begin bad++; $display("FAIL restart_pix got=%b want=0", pixOut); end
        if (nvramOE !== 1'b1) begin bad++; $display("FAIL restart_oe got=%b want=1", nvramOE); end
        if (dut.state_q !== VBLANK) begin bad++; $display("FAIL restart_state got=%0d want=%0d", dut.state_q, VBLANK); end
    endtask

    task automatic test_mid_reset;
        for (int h = 0; h <= 300; h++) step(10'(h), 10'd100);
        total += 3;
        if (nvramOE !== 1'b0) begin bad++; $display("FAIL midrst_pre_oe got=%b want=0", nvramOE); end
        if (vramAddr !== {9'd1, 6'd30}) begin bad++; $display("FAIL midrst_pre_addr got=%h want=%h", vramAddr, {9'd1, 6'd30}); end
        if (pixActive !== 1'b1) begin bad++; $display("FAIL midrst_pre_active got=%b want=1", pixActive); end
        reset = 1'b1;
        #1;
        total += 4;
        if (nvramOE !== 1'b1) begin bad++; $display("FAIL midrst_oe got=%b want=1", nvramOE); end
        if (vramAddr !== 15'h0) begin bad++; $display("FAIL midrst_addr got=%h want=0000", vramAddr); end
        if (pixOut !== 1'b0) begin bad++; $display("FAIL midrst_pix got=%b want=0", pixOut); end
        if (pixActive !== 1'b0) begin bad++; $display("FAIL midrst_active got=%b want=0", pixActive); end
        for (int h = 301; h <= 305; h++) step(10'(h), 10'd100);
        reset = 1'b0;
        for (int h = 306; h < 800; h++) begin
            step(10'(h), 10'd100);
            total += 2;
            if (nvramOE !== 1'b1) begin bad++; $display("FAIL midrst_idle_oe h=%0d got=%b want=1", h, nvramOE); end
            if (pixActive !== 1'b0) begin bad++; $display("FAIL midrst_idle_active h=%0d got=%b want=0", h, pixActive); end
        end
    endtask

    initial begin
        test_reset;
        test_vblank_quiet(10'd0, 100);
        test_vblank_quiet(10'd68, 800);
        test_full_line(10'd69, 9'd0, 1'b0);
        test_full_line(10'd70, 9'd1, 1'b1);
        test_fast_lines;
        test_full_line(10'd410, 9'd341, 1'b0);
        test_frame_end;
        test_vblank_quiet(10'd479, 100);
        test_vblank_quiet(10'd0, 100);
        test_full_line(10'd69, 9'd0, 1'b0);
        test_vcount_restart;
        test_vblank_quiet(10'd0, 100);
        test_full_line(10'd69, 9'd0, 1'b0);
        test_mid_reset;
        test_vblank_quiet(10'd0, 100);
        test_vblank_quiet(10'd68, 800);
        test_full_line(10'd69, 9'd0, 1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
